// File: rtl/array_feeder.sv
// Tile buffer + diagonal skew feeder for the PE array: K beats in, one CLEAR cycle, K+rows+cols-1 skewed STREAM cycles, one DONE cycle.
// Outputs are registered (first stream word one cycle after CLEAR); in_ready only in LOAD, so loads stall while a tile is replayed.
module array_feeder #(
    parameter int width = 16,
    parameter int rows  = 4,
    parameter int cols  = 4,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [cols*width-1:0]        in_data,
    input  logic [rows*width-1:0]        w_data,
    output logic [cols*width-1:0]        ins,
    output logic [rows*width-1:0]        ws,
    output logic [rows*cols*2-1:0]       ctls,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(depth+1)-1:0]   tile_len
);

    localparam int KW = $clog2(depth + 1);
    localparam int TW = $clog2(depth + rows + cols);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_STREAM, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           cnt_q, cnt_d;
    logic [KW-1:0]           k_q, k_d;
    logic [TW-1:0]           t_q, t_d;
    logic [cols*width-1:0]   ins_q, ins_d;
    logic [rows*width-1:0]   ws_q, ws_d;
    logic [rows*cols*2-1:0]  ctls_q, ctls_d;
    logic                    accept;

    logic [cols*width-1:0]   a_mem [depth];
    logic [rows*width-1:0]   w_mem [depth];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        t_d     = t_q;
        accept  = (state_q == S_LOAD) && in_valid;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (in_last || (int'(cnt_q) + 1 == depth)) begin
                        k_d     = cnt_q + 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                t_d     = '0;
            end
            S_STREAM: begin
                if (int'(t_q) == int'(k_q) + rows + cols - 2) state_d = S_DONE;
                else                                          t_d     = t_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_LOAD;
                cnt_d   = '0;
                t_d     = '0;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Output registers are loaded from the next-cycle state so they line up with state_q.
    always_comb begin
        int idx;
        idx    = 0;
        ins_d  = '0;
        ws_d   = '0;
        ctls_d = '0;
        if (state_d == S_CLEAR) begin
            for (int p = 0; p < rows*cols; p++) ctls_d[2*p +: 2] = 2'b10;
        end else if (state_d == S_STREAM) begin
            for (int c = 0; c < cols; c++) begin
                idx = int'(t_d) - c;
                if (idx >= 0 && idx < int'(k_q))
                    ins_d[c*width +: width] = a_mem[AW'(idx)][c*width +: width];
            end
            for (int r = 0; r < rows; r++) begin
                idx = int'(t_d) - r;
                if (idx >= 0 && idx < int'(k_q))
                    ws_d[r*width +: width] = w_mem[AW'(idx)][r*width +: width];
            end
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < cols; c++) begin
                    if (int'(t_d) >= r + c + 1 && int'(t_d) <= r + c + int'(k_q))
                        ctls_d[2*(c*rows+r) +: 2] = 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            k_q     <= '0;
            t_q     <= '0;
            ins_q   <= '0;
            ws_q    <= '0;
            ctls_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            t_q     <= t_d;
            ins_q   <= ins_d;
            ws_q    <= ws_d;
            ctls_q  <= ctls_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_mem[cnt_q[AW-1:0]] <= in_data;
            w_mem[cnt_q[AW-1:0]] <= w_data;
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_LOAD);
    assign done     = (state_q == S_DONE);
    assign tile_len = k_q;
    assign ins      = ins_q;
    assign ws       = ws_q;
    assign ctls     = ctls_q;

endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder: timing-based reference model checked every cycle, plus literal pins.
module tb_array_feeder;
    localparam int WD = 16;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int D  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [C*WD-1:0]   in_data = '0;
    logic [R*WD-1:0]   w_data = '0;
    logic [C*WD-1:0]   ins;
    logic [R*WD-1:0]   ws;
    logic [2*R*C-1:0]  ctls;
    logic              busy, done;
    logic [3:0]        tile_len;

    int n_cmp = 0;
    int n_bad = 0;

    array_feeder #(.width(WD), .rows(R), .cols(C), .depth(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .w_data(w_data),
        .ins(ins), .ws(ws), .ctls(ctls), .busy(busy), .done(done),
        .tile_len(tile_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Model: n counts cycles after the final accepting edge (0 = CLEAR, 1.. = stream t=n-1, K+R+C = DONE).
    logic [C*WD-1:0] m_a[$];
    logic [R*WD-1:0] m_w[$];
    bit m_loading = 1'b1;
    int m_n = 0;
    int m_k = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 1'b1;
            m_a.delete();
            m_w.delete();
            m_n = 0;
            m_k = 0;
        end else if (m_loading) begin
            if (in_valid) begin
                m_a.push_back(in_data);
                m_w.push_back(w_data);
                if (in_last || m_a.size() == D) begin
                    m_loading = 1'b0;
                    m_k = m_a.size();
                    m_n = 0;
                end
            end
        end else if (m_n == m_k + R + C) begin
            m_loading = 1'b1;
            m_a.delete();
            m_w.delete();
        end else begin
            m_n++;
        end
    end

    always @(negedge clk) begin
        logic [C*WD-1:0]  e_ins;
        logic [R*WD-1:0]  e_ws;
        logic [2*R*C-1:0] e_ctl;
        int t, i;
        e_ins = '0;
        e_ws  = '0;
        e_ctl = '0;
        t = 0;
        i = 0;
        if (!m_loading && !rst) begin
            if (m_n == 0) begin
                for (int p = 0; p < R*C; p++) e_ctl[2*p +: 2] = 2'b10;
            end else if (m_n <= m_k + R + C - 1) begin
                t = m_n - 1;
                for (int c = 0; c < C; c++) begin
                    i = t - c;
                    if (i >= 0 && i < m_k) e_ins[c*WD +: WD] = m_a[i][c*WD +: WD];
                end
                for (int r = 0; r < R; r++) begin
                    i = t - r;
                    if (i >= 0 && i < m_k) e_ws[r*WD +: WD] = m_w[i][r*WD +: WD];
                end
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        if (t >= r + c + 1 && t <= r + c + m_k) e_ctl[2*(c*R+r) +: 2] = 2'b01;
            end
        end
        chk("ins", ins, e_ins);
        chk("ws", ws, e_ws);
        chk("ctls", 64'(ctls), 64'(e_ctl));
        chk("busy", 64'(busy), 64'(!m_loading));
        chk("done", 64'(done), 64'(!m_loading && m_n == m_k + R + C));
        chk("in_ready", 64'(in_ready), 64'(m_loading));
        chk("tile_len", 64'(tile_len), 64'(m_k));
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic beat(input logic [63:0] a, input logic [63:0] w, input logic last);
        int guard;
        bit ok;
        guard = 0;
        in_valid = 1'b1;
        in_data = a;
        w_data = w;
        in_last = last;
        do begin
            ok = in_ready;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end while (!ok && guard < 200);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept: no acceptance within 200 cycles");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: no done pulse within 100 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ins", ins, 64'h0);
        chk("rst_ctls", 64'(ctls), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 64'(in_ready), 64'h1);

        // K=1 tile
        beat(v4(1, 2, 3, 4), v4(5, 6, 7, 8), 1'b1);
        chk("k1_clear", 64'(ctls), 64'h0000_0000_AAAA_AAAA);
        chk("k1_len", 64'(tile_len), 64'h1);
        @(negedge clk);
        chk("k1_t0_ins", ins, v4(1, 0, 0, 0));
        chk("k1_t0_ws", ws, v4(5, 0, 0, 0));
        @(negedge clk);
        chk("k1_t1_ctls", 64'(ctls), 64'h1);
        repeat (2) @(negedge clk);
        chk("k1_t3_ins", ins, v4(0, 0, 0, 4));
        chk("k1_t3_ws", ws, v4(0, 0, 0, 8));
        repeat (4) @(negedge clk);
        chk("k1_t7_ctls", 64'(ctls), 64'h4000_0000);
        @(negedge clk);
        chk("k1_done", 64'(done), 64'h1);
        @(negedge clk);
        chk("k1_rdy_back", 64'(in_ready), 64'h1);

        // Full tile, no in_last
        for (int b = 0; b < 8; b++)
            beat(v4(b*16+1, b*16+2, b*16+3, b*16+4), v4(b*16+9, b*16+10, b*16+11, b*16+12), 1'b0);
        chk("full_rdy_low", 64'(in_ready), 64'h0);
        chk("full_len", 64'(tile_len), 64'h8);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 7)  chk("full_pe33_t6", 64'(ctls[31:30]), 64'h0);
            if (n == 8)  chk("full_pe33_t7", 64'(ctls[31:30]), 64'h1);
            if (n == 15) chk("full_pe33_t14", 64'(ctls[31:30]), 64'h1);
            if (n == 15) chk("full_t14_nodone", 64'(done), 64'h0);
            if (n == 16) chk("full_done", 64'(done), 64'h1);
        end
        @(negedge clk);

        // Backpressure: valid 1,0,0,1,1(last)
        beat(v4(16'h11, 16'h12, 16'h13, 16'h14), v4(16'h21, 16'h22, 16'h23, 16'h24), 1'b0);
        in_data = v4(16'hdead, 16'hdead, 16'hdead, 16'hdead);
        w_data  = v4(16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef);
        in_last = 1'b1;
        repeat (2) @(negedge clk);
        in_last = 1'b0;
        beat(v4(16'h31, 16'h32, 16'h33, 16'h34), v4(16'h41, 16'h42, 16'h43, 16'h44), 1'b0);
        beat(v4(16'h51, 16'h52, 16'h53, 16'h54), v4(16'h61, 16'h62, 16'h63, 16'h64), 1'b1);
        chk("bp_len", 64'(tile_len), 64'h3);
        @(negedge clk);
        chk("bp_t0_ins", ins, v4(16'h11, 0, 0, 0));
        @(negedge clk);
        chk("bp_t1_ins", ins, v4(16'h31, 16'h12, 0, 0));
        wait_done(cyc);
        chk("bp_cycles", 64'(cyc), 64'd9);
        @(negedge clk);

        // Back-to-back: second tile offered while the first is busy
        beat(v4(7, 7, 7, 7), v4(8, 8, 8, 8), 1'b0);
        beat(v4(9, 9, 9, 9), v4(10, 10, 10, 10), 1'b1);
        beat(v4(16'ha1, 16'ha2, 16'ha3, 16'ha4), v4(16'hb1, 16'hb2, 16'hb3, 16'hb4), 1'b0);
        chk("b2b_still_loading", 64'(busy), 64'h0);
        beat(v4(16'hc1, 16'hc2, 16'hc3, 16'hc4), v4(16'hd1, 16'hd2, 16'hd3, 16'hd4), 1'b1);
        @(negedge clk);
        chk("b2b_t0_ins", ins, v4(16'ha1, 0, 0, 0));
        wait_done(cyc);
        chk("b2b_cycles", 64'(cyc), 64'd9);
        @(negedge clk);

        // Reset at stream t=4
        for (int b = 0; b < 4; b++)
            beat(v4(b+1, b+2, b+3, b+4), v4(b+5, b+6, b+7, b+8), b == 3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ins", ins, 64'h0);
        chk("mid_rst_ctls", 64'(ctls), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        beat(v4(3, 1, 4, 1), v4(5, 9, 2, 6), 1'b0);
        beat(v4(5, 3, 5, 8), v4(9, 7, 9, 3), 1'b1);
        chk("post_rst_len", 64'(tile_len), 64'h2);
        wait_done(cyc);
        chk("post_rst_cycles", 64'(cyc), 64'd10);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/array_feeder.md
# array_feeder

Skewing front-end that drives the systolic PE array's `ins`, `ws` and `ctls` inputs. It buffers one tile of K input vectors and K weight vectors through a valid/ready load port. It then replays them with the diagonal skew the array needs: column c delayed c cycles, row r delayed r cycles. It also generates the per-PE control field so each PE accumulates exactly while its K operand pairs are present.

## Interface
Parameters:
- `width`, 16: data word width (fixed-point, passed through unmodified).
- `rows`, 4: PE rows; number of weight lanes.
- `cols`, 4: PE columns; number of input lanes.
- `depth`, 8: maximum tile length K (beats); ≥ 1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  load beat valid.
- `in_ready`  out  1  feeder accepts a beat (LOAD state only).
- `in_last`  in  1  marks final beat of tile; sampled with the beat.
- `in_data`  in  cols*width  input vector; lane c at `[(c+1)*width-1 : c*width]`.
- `w_data`  in  rows*width  weight vector; lane r at `[(r+1)*width-1 : r*width]`.
- `ins`  out  cols*width  to array `ins`.
- `ws`  out  rows*width  to array `ws`.
- `ctls`  out  rows*cols*2  to array `ctls`. PE(r,c) field is `[2*(c*rows+r)+1 : 2*(c*rows+r)]` (column-major).
- `busy`  out  1  high in CLEAR/STREAM/DONE.
- `done`  out  1  one-cycle pulse at tile end.
- `tile_len`  out  $clog2(depth+1)  K of the tile being streamed.

## Operation
- Control codes per PE: 2'b00 HOLD, 2'b01 MAC, 2'b10 CLEAR, 2'b11 unused (never driven).
- Storage: depth entries of {in_data, w_data}; write pointer counts accepted beats.
- States: LOAD → CLEAR → STREAM → DONE → LOAD.
- LOAD:
  - `in_ready`=1; a beat is accepted when `in_valid & in_ready`.
  - Accepted beat i stores A[i] = in_data and W[i] = w_data.
  - On an accepted beat with `in_last`=1, or on the depth-th accepted beat, K = count and the state goes to CLEAR.
  - `in_last` on the depth-th beat is redundant, not an error.
- CLEAR: exactly 1 cycle; every `ctls` field = 2'b10; `ins`/`ws` = 0.
- STREAM, with stream counter t = 0 .. K+rows+cols-2:
  - `ins` lane c = A[t-c][c] if 0 ≤ t-c < K, else 0.
  - `ws` lane r = W[t-r][r] if 0 ≤ t-r < K, else 0.
  - PE(r,c) ctl = 2'b01 when r+c+1 ≤ t ≤ r+c+K, else 2'b00. The +1 accounts for the array's input register; the per-hop delay is 1 cycle.
  - After t = K+rows+cols-2, the state goes to DONE.
- DONE: 1 cycle; `done`=1; all ctls 2'b00; `ins`/`ws` = 0. Next state is LOAD with the write pointer cleared.
- `ins`, `ws` and `ctls` are registered outputs; the values above are the registered values during cycle t.

## Timing
- Reset (asynchronous, immediate):
  - State = LOAD, counters = 0.
  - `ins`, `ws`, `ctls`, `busy`, `done`, `tile_len` = 0.
  - `in_ready` = 1 once `rst` deasserts.
- Reset mid-STREAM aborts the tile; buffered data is discarded; no `done` pulse.
- The first STREAM cycle immediately follows the single CLEAR cycle, which follows the accepting edge of the last beat.
- STREAM lasts K+rows+cols-1 cycles. The whole tile occupies K (load, no stalls) + 1 + K+rows+cols-1 + 1 cycles.
- `in_ready` is 0 from the cycle after the last beat is accepted until the cycle after `done`.
- `in_valid` low during LOAD stalls loading with no side effects; data is sampled only on accepted beats.
- Back-to-back tiles: `in_ready`=1 the cycle after `done`.

## Test plan
- Reset: assert `rst` mid-cycle → `ins`/`ws`/`ctls`/`done`/`busy` = 0 at once; after release `in_ready`=1.
- K=1 tile (rows=cols=4): A=[1,2,3,4], W=[5,6,7,8], with `in_last` →
  - one cycle with all ctls 2'b10;
  - t=0: ins lane0=1 and ws lane0=5, other lanes 0;
  - t=3: ins lane3=4, ws lane3=8;
  - PE(0,0) MAC only at t=1; PE(3,3) MAC only at t=7;
  - `done` on the cycle after t=7.
- Full tile: 8 beats with `in_last`=0 → `in_ready` drops after beat 8; `tile_len`=8; STREAM lasts 15 cycles; PE(3,3) MAC for t=7..14.
- Backpressure: `in_valid` pattern 1,0,0,1,1(last) → only 3 beats stored, K=3; streamed values match accepted beats in order.
- Back-to-back: second tile offered while busy is not accepted until the cycle after `done`; its stream carries only the new data.
- Reset at STREAM t=4 → outputs 0, no `done`; next tile loads and streams correctly.
